sad_disparity_row: RTL and testbench



---
 rtl/sad_disparity_row_pkg.sv | 30 +++
 rtl/sad_disparity_row_argmin.sv | 72 +++++++
 rtl/sad_disparity_row.sv | 163 ++++++++++++++++
 tb/tb_sad_disparity_row.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sad_disparity_row_pkg.sv
// Shared constants and helpers for the stereo SAD disparity pipeline.
// Video timing defaults plus a constant clog2 usable in parameter lists.
package sad_disparity_row_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;
    localparam int PIX_W        = 8;
    localparam int MAXD_DEF     = 16;
    localparam int WIN_DEF      = 5;

    typedef logic [PIX_W-1:0] pix_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) begin
                r++;
            end
        end
        return r;
    endfunction

    function automatic pix_t abs_diff(input pix_t x, input pix_t y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/sad_disparity_row_argmin.sv
// Pipelined argmin tree over MAXD SAD values, one register per level.
// On equal values the lower index wins.
module sad_argmin
    import sad_disparity_row_pkg::*;
#(
    parameter int MAXD = 16,
    parameter int SW = 11,
    localparam int DW = clog2(MAXD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [SW-1:0] sad_i [MAXD],
    output logic [SW-1:0] min_o,
    output logic [DW-1:0] idx_o
);

    localparam int LV = DW;
    localparam int HW = MAXD / 2;

    logic [SW-1:0] val_d [LV][HW];
    logic [SW-1:0] val_q [LV][HW];
    logic [DW-1:0] idx_d [LV][HW];
    logic [DW-1:0] idx_q [LV][HW];

    always_comb begin
        for (int l = 0; l < LV; l++) begin
            for (int i = 0; i < HW; i++) begin
                val_d[l][i] = '0;
                idx_d[l][i] = '0;
            end
        end
        for (int i = 0; i < HW; i++) begin
            if (sad_i[2*i+1] < sad_i[2*i]) begin
                val_d[0][i] = sad_i[2*i+1];
                idx_d[0][i] = DW'(2*i+1);
            end else begin
                val_d[0][i] = sad_i[2*i];
                idx_d[0][i] = DW'(2*i);
            end
        end
        // strict less-than keeps the left (lower-index) operand on ties
        for (int l = 1; l < LV; l++) begin
            for (int i = 0; i < (MAXD >> (l + 1)); i++) begin
                if (val_q[l-1][2*i+1] < val_q[l-1][2*i]) begin
                    val_d[l][i] = val_q[l-1][2*i+1];
                    idx_d[l][i] = idx_q[l-1][2*i+1];
                end else begin
                    val_d[l][i] = val_q[l-1][2*i];
                    idx_d[l][i] = idx_q[l-1][2*i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LV; l++) begin
                for (int i = 0; i < HW; i++) begin
                    val_q[l][i] <= '0;
                    idx_q[l][i] <= '0;
                end
            end
        end else begin
            val_q <= val_d;
            idx_q <= idx_d;
        end
    end

    assign min_o = val_q[LV-1][0];
    assign idx_o = idx_q[LV-1][0];

endmodule

// File: rtl/sad_disparity_row.sv
// 1-D SAD block matching along a rectified row: abs-diff, running window sum,
// argmin tree; coordinates and validity ride a matching delay line.
module sad_disparity_row
    import sad_disparity_row_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int MAXD = MAXD_DEF,
    parameter int WIN = WIN_DEF,
    localparam int DW = clog2(MAXD),
    localparam int CW = PIX_W + clog2(WIN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   ix,
    input  logic [31:0]   iy,
    input  logic [7:0]    a,
    input  logic [7:0]    b,
    output logic [31:0]   ox,
    output logic [31:0]   oy,
    output logic [DW-1:0] disp,
    output logic          disp_valid,
    output logic [CW-1:0] cost
);

    localparam int LAT = 2 + DW;
    localparam int VALID_X = MAXD + WIN - 2;

    logic active;
    logic row_start;
    logic vld_in;
    logic row_ok_d, row_ok_q;

    pix_t bx [MAXD];
    pix_t r_d [MAXD-1];
    pix_t r_q [MAXD-1];
    pix_t c_d [MAXD];
    pix_t c_q [MAXD];
    logic act1_d, act1_q;
    logic start1_d, start1_q;

    pix_t          hist_d [MAXD][WIN];
    pix_t          hist_q [MAXD][WIN];
    logic [CW-1:0] sum_d [MAXD];
    logic [CW-1:0] sum_q [MAXD];

    logic [31:0]    ix_p_d [LAT];
    logic [31:0]    ix_p_q [LAT];
    logic [31:0]    iy_p_d [LAT];
    logic [31:0]    iy_p_q [LAT];
    logic [LAT-1:0] v_p_d, v_p_q;

    logic [CW-1:0] min_sad;
    logic [DW-1:0] min_idx;

    assign active = (ix < 32'(H_ACTIVE)) && (iy < 32'(V_ACTIVE));
    assign row_start = active && (ix == 32'd0);
    // rows interrupted by reset stay invalid until a fresh row start
    assign vld_in = active && row_ok_q && (ix >= 32'(VALID_X));
    assign row_ok_d = row_ok_q | row_start;
    assign act1_d = active;
    assign start1_d = row_start;

    always_comb begin
        bx[0] = b;
        for (int d = 1; d < MAXD; d++) begin
            bx[d] = row_start ? '0 : r_q[d-1];
        end
        r_d = r_q;
        if (active) begin
            for (int d = 0; d < MAXD - 1; d++) begin
                r_d[d] = bx[d];
            end
        end
        for (int d = 0; d < MAXD; d++) begin
            c_d[d] = abs_diff(a, bx[d]);
        end
    end

    always_comb begin
        hist_d = hist_q;
        sum_d = sum_q;
        if (act1_q) begin
            for (int d = 0; d < MAXD; d++) begin
                if (start1_q) begin
                    sum_d[d] = CW'(c_q[d]);
                    for (int w = 0; w < WIN; w++) begin
                        hist_d[d][w] = '0;
                    end
                end else begin
                    sum_d[d] = sum_q[d] + CW'(c_q[d])
                             - CW'(hist_q[d][WIN-1]);
                    for (int w = 1; w < WIN; w++) begin
                        hist_d[d][w] = hist_q[d][w-1];
                    end
                end
                hist_d[d][0] = c_q[d];
            end
        end
    end

    always_comb begin
        ix_p_d[0] = ix;
        iy_p_d[0] = iy;
        for (int i = 1; i < LAT; i++) begin
            ix_p_d[i] = ix_p_q[i-1];
            iy_p_d[i] = iy_p_q[i-1];
        end
        v_p_d = {v_p_q[LAT-2:0], vld_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_ok_q <= 1'b0;
            act1_q <= 1'b0;
            start1_q <= 1'b0;
            v_p_q <= '0;
            for (int d = 0; d < MAXD - 1; d++) begin
                r_q[d] <= '0;
            end
            for (int d = 0; d < MAXD; d++) begin
                c_q[d] <= '0;
                sum_q[d] <= '0;
                for (int w = 0; w < WIN; w++) begin
                    hist_q[d][w] <= '0;
                end
            end
            for (int i = 0; i < LAT; i++) begin
                ix_p_q[i] <= '0;
                iy_p_q[i] <= '0;
            end
        end else begin
            row_ok_q <= row_ok_d;
            act1_q <= act1_d;
            start1_q <= start1_d;
            v_p_q <= v_p_d;
            r_q <= r_d;
            c_q <= c_d;
            sum_q <= sum_d;
            hist_q <= hist_d;
            ix_p_q <= ix_p_d;
            iy_p_q <= iy_p_d;
        end
    end

    sad_argmin #(
        .MAXD (MAXD),
        .SW   (CW)
    ) u_argmin (
        .clk   (clk),
        .rst_n (rst_n),
        .sad_i (sum_q),
        .min_o (min_sad),
        .idx_o (min_idx)
    );

    assign ox = ix_p_q[LAT-1];
    assign oy = iy_p_q[LAT-1];
    assign disp_valid = v_p_q[LAT-1];
    assign disp = disp_valid ? min_idx : '0;
    assign cost = disp_valid ? min_sad : '0;

endmodule

// File: tb/tb_sad_disparity_row.sv
// Directed bench for sad_disparity_row: known-shift rows, flat rows,
// blanking, frame wrap and mid-row reset against hand-derived results.
module tb_sad_disparity_row;

    localparam int LAT = 6;
    localparam int NVLD = 621;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        v;
        logic [3:0]  d;
        logic [10:0] c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] ix = '0;
    logic [31:0] iy = '0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [31:0] ox;
    logic [31:0] oy;
    logic [3:0]  disp;
    logic        disp_valid;
    logic [10:0] cost;

    exp_t q[$];
    exp_t me;
    bit   mon_en = 1'b0;
    bit   seen_v = 1'b0;
    int   n_chk = 0;
    int   n_ok = 0;
    int   n_bad = 0;
    int   n_vld = 0;
    int   cyc = 0;
    int   t19 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    sad_disparity_row dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ix         (ix),
        .iy         (iy),
        .a          (a),
        .b          (b),
        .ox         (ox),
        .oy         (oy),
        .disp       (disp),
        .disp_valid (disp_valid),
        .cost       (cost)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic bit is_spot(input logic [31:0] x);
        return x == 0 || x == 18 || x == 19 || x == 20 ||
               x == 300 || x == 639 || x == 640;
    endfunction

    always @(negedge clk) begin
        if (mon_en && q.size() > LAT) begin
            me = q.pop_front();
            if (ox !== me.x || oy !== me.y || disp_valid !== me.v ||
                disp !== me.d || cost !== me.c) n_bad++;
            if (disp_valid === 1'b1) n_vld++;
            if (is_spot(me.x)) begin
                chk($sformatf("ox@%0d/%0d", me.x, me.y), ox, me.x);
                chk($sformatf("vld@%0d/%0d", me.x, me.y),
                    32'(disp_valid), 32'(me.v));
                chk($sformatf("disp@%0d/%0d", me.x, me.y),
                    32'(disp), 32'(me.d));
                chk($sformatf("cost@%0d/%0d", me.x, me.y),
                    32'(cost), 32'(me.c));
            end
        end
        if (mon_en && disp_valid === 1'b1 && !seen_v) begin
            seen_v = 1'b1;
            chk("lat", 32'(cyc - t19), 32'(LAT));
        end
    end

    task automatic pix(input int x, input int y, input logic [7:0] pa,
                       input logic [7:0] pb, input bit good,
                       input logic [3:0] ed, input logic [10:0] ec);
        exp_t e;
        ix = 32'(x);
        iy = 32'(y);
        a = pa;
        b = pb;
        e.x = 32'(x);
        e.y = 32'(y);
        e.v = good && x < 640 && y < 480 && x >= 19;
        e.d = e.v ? ed : 4'd0;
        e.c = e.v ? ec : 11'd0;
        q.push_back(e);
        if (x == 0) seen_v = 1'b0;
        if (x == 19) t19 = cyc;
        @(posedge clk);
        #1;
    endtask

    // kind 0: shift 5; 1: flat; 2: shift 3 with lsb noise; 3: a=0,b=255
    task automatic row(input int y, input int kind, input int rst_at);
        logic [7:0]  pa, pb;
        logic [3:0]  ed;
        logic [10:0] ec;
        bit          g;
        g = 1'b1;
        for (int x = 0; x < 800; x++) begin
            case (kind)
                0: begin
                    pb = 8'((7 * x) & 255);
                    pa = 8'((7 * (x - 5)) & 255);
                    ed = 4'd5; ec = 11'd0;
                end
                1: begin
                    pb = 8'd100; pa = 8'd100;
                    ed = 4'd0; ec = 11'd0;
                end
                2: begin
                    pb = 8'((37 * x) & 255);
                    pa = 8'(((37 * (x - 3)) & 255) ^ 1);
                    ed = 4'd3; ec = 11'd5;
                end
                default: begin
                    pb = 8'd255; pa = 8'd0;
                    ed = 4'd0; ec = 11'd1275;
                end
            endcase
            if (x == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_ox", ox, 0);
                chk("rst_oy", oy, 0);
                chk("rst_vld", 32'(disp_valid), 0);
                chk("rst_disp", 32'(disp), 0);
                chk("rst_cost", 32'(cost), 0);
                mon_en = 1'b0;
            end
            if (rst_at >= 0 && x == rst_at + 2) begin
                rst_n = 1'b1;
                q.delete();
                mon_en = 1'b1;
                g = 1'b0;
            end
            pix(x, y, pa, pb, g, ed, ec);
        end
    endtask

    task automatic phase_end(input string tag, input int exp_vld,
                             input bit use_vld);
        chk({tag, "_bad"}, 32'(n_bad), 0);
        if (use_vld) chk({tag, "_vld"}, 32'(n_vld), 32'(exp_vld));
        n_bad = 0;
        n_vld = 0;
    endtask

    initial begin
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ix = $urandom;
            iy = $urandom;
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk);
            #1;
            chk("r0_ox", ox, 0);
            chk("r0_oy", oy, 0);
            chk("r0_vld", 32'(disp_valid), 0);
            chk("r0_disp", 32'(disp), 0);
            chk("r0_cost", 32'(cost), 0);
        end
        rst_n = 1'b1;
        q.delete();
        mon_en = 1'b1;

        row(10, 0, -1);
        phase_end("shift5", NVLD, 1'b1);
        row(11, 1, -1);
        phase_end("flat", NVLD, 1'b1);
        row(12, 2, -1);
        phase_end("shift3", NVLD, 1'b1);
        row(20, 3, -1);
        phase_end("sat", NVLD, 1'b1);
        row(480, 3, -1);
        row(524, 3, -1);
        phase_end("vblank", 0, 1'b1);
        row(0, 0, -1);
        phase_end("wrap", NVLD, 1'b1);
        row(1, 0, 300);
        phase_end("midrst", 0, 1'b0);
        row(2, 0, -1);
        phase_end("after", NVLD, 1'b1);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
